// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
//
// Command-side master for a registered ALU. A command is accepted over a
// valid/ready handshake and its operands and select are registered onto the
// ALU inputs. The driver waits out the ALU latency and captures the result.
// The result is returned over a valid/ready response handshake.
// When chaining, the previous captured result replaces operand A.
// A wrapping counter tracks completed responses.
//
// Parameters
//   WIDTH    operand / result width
//   LATENCY  ALU clock edges from stable operands to valid result
//   CNT_W    width of the completed-operation counter
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_a, cmd_b, cmd_sel          command operands and select
//                                  (00 add, 01 A-B, 10 B-A, 11 mul)
//   cmd_chain                      use last captured result as operand A
//   alu_a, alu_b, alu_sel          registered ALU inputs
//   alu_result                     registered ALU output
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_sel              captured result and its select
//   op_count                       completed responses (wraps)
// ---------------------------------------------------------------------------
module alu_cmd_driver #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [1:0]       cmd_sel,
   input  logic             cmd_chain,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [1:0]       rsp_sel,
   output logic [CNT_W-1:0] op_count
);

   // Wait counter must hold the value LATENCY; keep it at least one bit wide.
   localparam int LAT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [LAT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   alu_a_q, alu_a_d;
   logic [WIDTH-1:0]   alu_b_q, alu_b_d;
   logic [1:0]         alu_sel_q, alu_sel_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic [1:0]         rsp_sel_q, rsp_sel_d;
   logic [WIDTH-1:0]   last_q, last_d;
   logic [CNT_W-1:0]   op_count_q, op_count_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               rsp_valid_q, rsp_valid_d;

   logic               cmd_fire_s;
   logic               rsp_fire_s;
   logic               cnt_zero_s;

   // cmd_ready_q is high exactly in IDLE and rsp_valid_q exactly in RESP,
   // so these handshakes already imply the correct state.
   assign cmd_fire_s = cmd_valid & cmd_ready_q;
   assign rsp_fire_s = rsp_valid_q & rsp_ready;
   assign cnt_zero_s = (cnt_q == {LAT_W{1'b0}});

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire_s) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_zero_s) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (rsp_fire_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output / datapath next values; everything holds unless a transition updates it.
   always_comb begin
      cnt_d      = cnt_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      rsp_data_d = rsp_data_q;
      rsp_sel_d  = rsp_sel_q;
      last_d     = last_q;
      op_count_d = op_count_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire_s) begin
               alu_a_d   = cmd_chain ? last_q : cmd_a;
               alu_b_d   = cmd_b;
               alu_sel_d = cmd_sel;
               cnt_d     = LAT_W'(LATENCY);
            end else begin
               cnt_d     = cnt_q;
            end
         end
         ST_WAIT: begin
            if (cnt_zero_s) begin
               rsp_data_d = alu_result;
               last_d     = alu_result;
               rsp_sel_d  = alu_sel_q;
            end else begin
               cnt_d      = cnt_q - {{(LAT_W-1){1'b0}}, 1'b1};
            end
         end
         ST_RESP: begin
            if (rsp_fire_s) begin
               op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               op_count_d = op_count_q;
            end
         end
         default: begin
            cnt_d = {LAT_W{1'b0}};
         end
      endcase
      // Handshake flags are registered from the next state so they line up
      // with the state they describe.
      cmd_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   // Datapath and handshake output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= {LAT_W{1'b0}};
         alu_a_q     <= {WIDTH{1'b0}};
         alu_b_q     <= {WIDTH{1'b0}};
         alu_sel_q   <= 2'b00;
         rsp_data_q  <= {WIDTH{1'b0}};
         rsp_sel_q   <= 2'b00;
         last_q      <= {WIDTH{1'b0}};
         op_count_q  <= {CNT_W{1'b0}};
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         rsp_data_q  <= rsp_data_d;
         rsp_sel_q   <= rsp_sel_d;
         last_q      <= last_d;
         op_count_q  <= op_count_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_sel   = rsp_sel_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// Testbench for alu_cmd_driver. Two instances share the command stimulus:
// one with the default 16-bit counter and one with a 2-bit counter to see
// the counter wrap. Each has its own registered ALU model (latency 1).
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_cmd_driver;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [1:0]  cmd_sel;
   logic        cmd_chain;
   logic        rsp_ready;

   logic        cmd_ready, rsp_valid;
   logic [7:0]  alu_a, alu_b, alu_result, rsp_data;
   logic [1:0]  alu_sel, rsp_sel;
   logic [15:0] op_count;

   logic        s_cmd_ready, s_rsp_valid;
   logic [7:0]  s_alu_a, s_alu_b, s_alu_result, s_rsp_data;
   logic [1:0]  s_alu_sel, s_rsp_sel;
   logic [1:0]  s_op_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] sel;
      logic       chain;
      logic [7:0] exp_alu_a;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [8];

   alu_cmd_driver #(.WIDTH(8), .LATENCY(1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_sel(rsp_sel), .op_count(op_count)
   );

   alu_cmd_driver #(.WIDTH(8), .LATENCY(1), .CNT_W(2)) dut_small (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
      .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_sel(s_alu_sel), .alu_result(s_alu_result),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(s_rsp_data), .rsp_sel(s_rsp_sel), .op_count(s_op_count)
   );

   // Reference ALU function (wraps modulo 256, multiply keeps low byte).
   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] sel);
      logic [15:0] p;
      p = 16'(a) * 16'(b);
      case (sel)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return b - a;
         default: return p[7:0];
      endcase
   endfunction

   // Registered ALU models, one clock of latency.
   always @(posedge clk) begin
      alu_result   <= alu_f(alu_a, alu_b, alu_sel);
      s_alu_result <= alu_f(s_alu_a, s_alu_b, s_alu_sel);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_cmd(input vec_t v);
      cmd_a     = v.a;
      cmd_b     = v.b;
      cmd_sel   = v.sel;
      cmd_chain = v.chain;
      cmd_valid = 1'b1;
   endtask

   // Called at the falling edge right after the accepting rising edge.
   task automatic finish_op(input vec_t v, input int cnt, input int scnt);
      check("alu_a", 32'(alu_a), 32'(v.exp_alu_a));
      check("alu_b", 32'(alu_b), 32'(v.b));
      check("alu_sel", 32'(alu_sel), 32'(v.sel));
      check("wait_cmd_ready", 32'(cmd_ready), 32'd0);
      check("wait_rsp_valid0", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("wait_rsp_valid1", 32'(rsp_valid), 32'd0);
      check("wait_cmd_ready1", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_data", 32'(rsp_data), 32'(v.exp_data));
      check("rsp_sel", 32'(rsp_sel), 32'(v.sel));
      check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("s_rsp_data", 32'(s_rsp_data), 32'(v.exp_data));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("post_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_cmd_ready", 32'(cmd_ready), 32'd1);
      check("op_count", 32'(op_count), 32'(cnt));
      check("s_op_count", 32'(s_op_count), 32'(scnt));
   endtask

   task automatic do_op(input vec_t v, input int cnt, input int scnt);
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      drive_cmd(v);
      @(negedge clk);
      cmd_valid = 1'b0;
      finish_op(v, cnt, scnt);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
      check({tag, "_rsp_sel"}, 32'(rsp_sel), 32'd0);
      check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
      check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
      check({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
      check({tag, "_op_count"}, 32'(op_count), 32'd0);
      check({tag, "_s_op_count"}, 32'(s_op_count), 32'd0);
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{8'd200, 8'd100, 2'b00, 1'b0, 8'd200, 8'd44};
      vecs[1] = '{8'd3,   8'd5,   2'b01, 1'b0, 8'd3,   8'd254};
      vecs[2] = '{8'd3,   8'd5,   2'b10, 1'b0, 8'd3,   8'd2};
      vecs[3] = '{8'd20,  8'd13,  2'b11, 1'b0, 8'd20,  8'd4};
      vecs[4] = '{8'd99,  8'd6,   2'b00, 1'b1, 8'd4,   8'd10};
      vecs[5] = '{8'd255, 8'd255, 2'b11, 1'b0, 8'd255, 8'd1};
      vecs[6] = '{8'd0,   8'd1,   2'b01, 1'b1, 8'd1,   8'd0};
      vecs[7] = '{8'd50,  8'd7,   2'b10, 1'b1, 8'd0,   8'd7};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0;
      cmd_sel = 2'b00; cmd_chain = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven ops; the small counter wraps 1,2,3,0,1,...
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i], i + 1, (i + 1) % 4);
      end

      // Backpressure: response held while a second command waits.
      v = '{8'd9, 8'd4, 2'b01, 1'b0, 8'd9, 8'd5};
      drive_cmd(v);
      @(negedge clk);
      drive_cmd('{8'd2, 8'd3, 2'b11, 1'b0, 8'd2, 8'd6});
      @(negedge clk);
      @(negedge clk);
      check("bp_rsp_valid_rise", 32'(rsp_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_data", 32'(rsp_data), 32'd5);
         check("bp_rsp_sel", 32'(rsp_sel), 32'd1);
         check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         check("bp_alu_a_held", 32'(alu_a), 32'd9);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp_post_rsp_valid", 32'(rsp_valid), 32'd0);
      check("bp_post_cmd_ready", 32'(cmd_ready), 32'd1);
      check("bp_op_count", 32'(op_count), 32'd9);
      check("bp_not_yet_accepted", 32'(alu_a), 32'd9);
      @(negedge clk);
      cmd_valid = 1'b0;
      finish_op('{8'd2, 8'd3, 2'b11, 1'b0, 8'd2, 8'd6}, 10, 2);

      // Reset mid-op: abort during WAIT.
      drive_cmd('{8'd1, 8'd1, 2'b00, 1'b0, 8'd1, 8'd2});
      @(negedge clk);
      check("mid_alu_a", 32'(alu_a), 32'd1);
      check("mid_cmd_ready", 32'(cmd_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_reset");
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("held_reset");
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
         check("count_after_reset", 32'(op_count), 32'd0);
      end

      // Chain right after reset uses last_result = 0.
      do_op('{8'd50, 8'd9, 2'b00, 1'b1, 8'd0, 8'd9}, 1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
